// File: rtl/mux4a1_arbiter.sv
// Round-robin arbiter/sequencer for a shared 4:1 mux with bounded bursts.
// Define MUX4A1_ARB_FIXED_PRIO_EN for fixed priority (Req[0] highest).
module mux4a1_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       Req,
  input  logic [WIDTH-1:0] Input0,
  input  logic [WIDTH-1:0] Input1,
  input  logic [WIDTH-1:0] Input2,
  input  logic [WIDTH-1:0] Input3,
  input  logic             OutReady,
  output logic [1:0]       Selector,
  output logic [3:0]       Grant,
  output logic [WIDTH-1:0] Output,
  output logic             OutValid,
  output logic [3:0]       Ack
);

  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {ARB, XFER} state_t;

  state_t           state, state_n;
  logic [1:0]       last, last_n;
  logic [BW-1:0]    burst, burst_n;
  logic [1:0]       win;
  logic [BW-1:0]    burst_w;
  logic [1:0]       sel_n;
  logic [3:0]       grant_n;
  logic [WIDTH-1:0] out_n;
  logic             valid_n;
  logic [WIDTH-1:0] word;

  always_comb begin
    word = Input0;
    unique case (win)
      2'd0: word = Input0;
      2'd1: word = Input1;
      2'd2: word = Input2;
      2'd3: word = Input3;
    endcase
  end

`ifdef MUX4A1_ARB_FIXED_PRIO_EN
  always_comb begin
    win     = 2'd0;
    burst_w = burst;
    priority case (1'b1)
      Req[0]:  win = 2'd0;
      Req[1]:  win = 2'd1;
      Req[2]:  win = 2'd2;
      Req[3]:  win = 2'd3;
      default: win = 2'd0;
    endcase
  end
`else
  logic       keep;
  logic       found;
  logic [1:0] cand;

  // Scan ends at last+4 so a sole requester wraps back to itself.
  always_comb begin
    keep    = Req[last] && (burst != '0) &&
              (burst < BW'(MAX_BURST));
    win     = last;
    burst_w = BW'(1);
    found   = 1'b0;
    cand    = last;
    if (keep) begin
      burst_w = burst + BW'(1);
    end else begin
      for (int k = 1; k <= 4; k++) begin
        cand = last + 2'(k);
        if (!found && Req[cand]) begin
          win   = cand;
          found = 1'b1;
        end
      end
    end
  end
`endif

  always_comb begin
    state_n = state;
    last_n  = last;
    burst_n = burst;
    sel_n   = Selector;
    grant_n = Grant;
    out_n   = Output;
    valid_n = OutValid;
    unique case (state)
      ARB: begin
        if (|Req) begin
          state_n = XFER;
          last_n  = win;
          burst_n = burst_w;
          sel_n   = win;
          grant_n = 4'b0001 << win;
          out_n   = word;
          valid_n = 1'b1;
        end
      end
      XFER: begin
        if (OutReady) begin
          state_n = ARB;
          grant_n = 4'b0000;
          valid_n = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ARB;
      last     <= 2'd3;
      burst    <= '0;
      Selector <= 2'd0;
      Grant    <= 4'b0000;
      Output   <= '0;
      OutValid <= 1'b0;
    end else begin
      state    <= state_n;
      last     <= last_n;
      burst    <= burst_n;
      Selector <= sel_n;
      Grant    <= grant_n;
      Output   <= out_n;
      OutValid <= valid_n;
    end
  end

  assign Ack = Grant & {4{OutValid & OutReady}};

endmodule

// File: tb/tb_mux4a1_arbiter.sv
// Directed scoreboard bench for mux4a1_arbiter (MAX_BURST=4 and =1).
// Expectations follow MUX4A1_ARB_FIXED_PRIO_EN when it is defined.
module tb_mux4a1_arbiter;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   Req;
  logic [W-1:0] in0, in1, in2, in3;
  logic         OutReady;

  logic [1:0]   a_sel, b_sel, sel;
  logic [3:0]   a_gnt, b_gnt, gnt;
  logic [W-1:0] a_out, b_out, dout;
  logic         a_ov, b_ov, ov;
  logic [3:0]   a_ack, b_ack, ack;

  mux4a1_arbiter #(.WIDTH(W), .MAX_BURST(4)) u0 (
    .clk(clk), .reset(reset), .Req(Req),
    .Input0(in0), .Input1(in1), .Input2(in2), .Input3(in3),
    .OutReady(OutReady), .Selector(a_sel), .Grant(a_gnt),
    .Output(a_out), .OutValid(a_ov), .Ack(a_ack)
  );

  mux4a1_arbiter #(.WIDTH(W), .MAX_BURST(1)) u1 (
    .clk(clk), .reset(reset), .Req(Req),
    .Input0(in0), .Input1(in1), .Input2(in2), .Input3(in3),
    .OutReady(OutReady), .Selector(b_sel), .Grant(b_gnt),
    .Output(b_out), .OutValid(b_ov), .Ack(b_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   idx;
    logic [W-1:0] data;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   pc[4];
  int   cnt[4];
  bit   upd;
  bit   mon1;
  int   n;

  always_comb begin
    sel  = mon1 ? b_sel : a_sel;
    gnt  = mon1 ? b_gnt : a_gnt;
    dout = mon1 ? b_out : a_out;
    ov   = mon1 ? b_ov  : a_ov;
    ack  = mon1 ? b_ack : a_ack;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_in(input int i, input logic [W-1:0] v);
    case (i)
      0: in0 = v;
      1: in1 = v;
      2: in2 = v;
      default: in3 = v;
    endcase
  endtask

  task automatic init_inputs();
    for (int i = 0; i < 4; i++) begin
      pc[i]  = 0;
      cnt[i] = 0;
      set_in(i, W'(16 * i));
    end
  endtask

  task automatic pushd(input int i, input logic [W-1:0] d);
    exp_t e;
    e.idx  = 2'(i);
    e.data = d;
    q.push_back(e);
  endtask

  task automatic push(input int i);
    pushd(i, W'(16 * i + pc[i]));
    pc[i]++;
  endtask

  // A handshake is visible before the edge that completes it.
  task automatic look();
    exp_t e;
    if (ov && OutReady) begin
      total++;
      assert (q.size() != 0) else begin
        bad++;
        $error("FAIL extra_xfer observed=sel%0d expected=none", sel);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sel", 32'(sel), 32'(e.idx));
        chk("grant", 32'(gnt), 32'(1) << e.idx);
        chk("ack", 32'(ack), 32'(1) << e.idx);
        chk("data", 32'(dout), 32'(e.data));
        if (upd) begin
          cnt[e.idx]++;
          set_in(int'(e.idx), W'(16 * int'(e.idx) + cnt[e.idx]));
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    look();
  endtask

  task automatic drain(input string tag, output int nc);
    nc = 0;
    while (q.size() > 0 && nc < 200) begin
      step();
      nc++;
    end
    chk(tag, 32'(q.size()), 32'd0);
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_sel"}, 32'(sel), 32'd0);
    chk({tag, "_gnt"}, 32'(gnt), 32'd0);
    chk({tag, "_out"}, 32'(dout), 32'd0);
    chk({tag, "_ov"}, 32'(ov), 32'd0);
    chk({tag, "_ack"}, 32'(ack), 32'd0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    Req      = 4'b0000;
    OutReady = 1'b0;
    mon1     = 1'b0;
    upd      = 1'b0;
    init_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_chk("reset");
    reset = 1'b0;

    // single requester, one transfer every 2 cycles
    step();
    in2      = 8'h5A;
    Req      = 4'b0100;
    OutReady = 1'b1;
    repeat (4) pushd(2, 8'h5A);
    step();
    chk("latency", 32'(ov), 32'd1);
    drain("single_drain", n);
    chk("single_thru", 32'(n), 32'd6);
    Req = 4'b0000;
    step();

    // reset asserted while a word is pending
    Req      = 4'b1111;
    OutReady = 1'b0;
    step();
    chk("pre_rst_ov", 32'(ov), 32'd1);
    reset = 1'b1;
    #1;
    rst_chk("midrst");
    step();
    reset = 1'b0;

    // all requesting, bursts of 4
    init_inputs();
    upd      = 1'b1;
    OutReady = 1'b1;
    for (int k = 0; k < 17; k++) begin
`ifdef MUX4A1_ARB_FIXED_PRIO_EN
      push(0);
`else
      push((k / 4) % 4);
`endif
    end
    drain("all_drain", n);
    Req = 4'b0000;
    step();

    // backpressure holds the latched word
    upd      = 1'b0;
    OutReady = 1'b0;
    in1      = 8'h21;
    Req      = 4'b0010;
    pushd(1, 8'h21);
    step();
    chk("bp_ov0", 32'(ov), 32'd1);
    in1 = 8'hFF;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_out", 32'(dout), 32'h21);
      chk("bp_ov", 32'(ov), 32'd1);
      chk("bp_ack", 32'(ack), 32'd0);
    end
    OutReady = 1'b1;
    #1;
    look();
    Req = 4'b0000;
    step();
    chk("bp_post_ov", 32'(ov), 32'd0);
    chk("bp_post_ack", 32'(ack), 32'd0);
    chk("bp_drain", 32'(q.size()), 32'd0);

    // MAX_BURST=1 instance: pure round-robin
    pulse_reset();
    init_inputs();
    mon1     = 1'b1;
    upd      = 1'b1;
    OutReady = 1'b1;
    Req      = 4'b1010;
`ifdef MUX4A1_ARB_FIXED_PRIO_EN
    repeat (4) push(1);
`else
    push(1); push(3); push(1); push(3);
`endif
    drain("rr1_drain", n);
    Req = 4'b0010;
    push(1);
    drain("rr1_drop", n);
    Req = 4'b0000;
    step();
    mon1 = 1'b0;

    // upper pair requesting
    pulse_reset();
    init_inputs();
    Req = 4'b1100;
`ifdef MUX4A1_ARB_FIXED_PRIO_EN
    repeat (8) push(2);
`else
    repeat (4) push(2);
    repeat (4) push(3);
`endif
    drain("hi_drain", n);
    Req = 4'b0000;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux4a1_arbiter.md
Name: mux4a1_arbiter

Overview:
- Round-robin arbiter and sequencer for the 4:1 WIDTH-bit datapath multiplexer.
- Four requesters each present a data word plus Req; the block grants one, drives the mux Selector, registers the selected word and delivers it downstream with a valid/ready handshake.
- Bounded bursts per grantee.
- Sits between the four producer blocks and the single shared downstream consumer.

Parameters:
- WIDTH, 8, data width of Input0..Input3 and Output
- MAX_BURST, 4, max consecutive transfers granted to one requester before priority rotates (>=1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- Req  input  4  Req[i]=1: requester i has a valid word on Input i
- Input0..Input3  input  WIDTH each  requester data words
- OutReady  input  1  downstream accepts Output this cycle
- Selector  output  2  index of current/last grantee; drives shared mux select
- Grant  output  4  one-hot current owner, 0 when idle
- Output  output  WIDTH  registered data word to downstream
- OutValid  output  1  Output holds an undelivered word
- Ack  output  4  one-cycle pulse, Ack[i]=Grant[i]&OutValid&OutReady (combinational)

Behaviour:
- Reset (async, immediate):
  - Selector=0, Grant=0, Output=0, OutValid=0, Ack=0.
  - Internal LastGrant=3, so index 0 has first priority.
  - BurstCnt=0.
  - State=ARB.
- States: ARB, XFER.
- ARB:
  - OutValid=0, Grant=0.
  - If Req==0: stay.
  - Else choose winner W:
    - If Req[LastGrant]=1 and 0<BurstCnt<MAX_BURST: W=LastGrant, BurstCnt+1.
    - Otherwise W = first set Req bit scanning LastGrant+1, +2, +3, +4 (mod 4), and BurstCnt=1.
  - At the clock edge: Selector<=W, Grant<=onehot(W), Output<=Input[W], OutValid<=1, LastGrant<=W, go XFER.
  - Latency: Req sampled high in ARB gives OutValid=1 on the following cycle.
- XFER:
  - Output, Selector and Grant are held stable; Input changes are ignored.
  - While OutReady=0: stay, no Ack.
  - When OutReady=1: Ack[W] pulses that cycle, then go ARB next edge with OutValid<=0 and Grant<=0.
  - Selector holds its last value in ARB.
- Throughput: max one transfer per 2 cycles (mandatory ARB bubble).
  - Requester i updates Input i, or drops Req[i], in the cycle after its Ack.
- Requester protocol: Req[i] must stay high until Ack[i]. Req deassertion in XFER has no effect; the latched word is still delivered.
- Burst rules:
  - If the owner drops Req in ARB, rotation proceeds from LastGrant+1 and BurstCnt restarts at 1.
  - Sole requester at MAX_BURST: the rotation scan wraps back to it, it is re-granted with BurstCnt=1, and no idle cycles are inserted beyond the ARB bubble.
- Simultaneous events: Req changes in the same cycle as the Ack handshake are evaluated in the following ARB cycle.
- Reset mid-XFER: word discarded, no Ack, all outputs cleared asynchronously.
- BurstCnt width: $clog2(MAX_BURST+1).
- MAX_BURST=1 gives pure per-transfer round-robin.

Optional Feature:
- Macro: MUX4A1_ARB_FIXED_PRIO_EN.
- Defined:
  - Winner is always the lowest-index set Req bit; Req[0] has highest priority.
  - MAX_BURST, BurstCnt and the rotation pointer are ignored.
  - Handshake and timing are unchanged.
- Undefined: round-robin with bursts as above.

Test Plan:
- Reset: assert reset mid-run with OutValid=1 -> Selector=0, Grant=0, Output=0x00, OutValid=0, Ack=0 immediately; first grant after release goes to index 0 when Req=4'b1111.
- Single requester: Req=4'b0100, Input2=0x5A, OutReady=1 -> OutValid=1 one cycle later, Selector=2, Grant=4'b0100, Output=0x5A, Ack=4'b0100 pulse; repeats every 2 cycles indefinitely.
- All requesting (Req=4'b1111), OutReady=1, MAX_BURST=4 -> grant sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0...; Output equals the corresponding Input each transfer (Input_i=0x10*i+count).
- Backpressure: granted index 1 with Output=0x21, OutReady=0 for 5 cycles while Input1 changes to 0xFF -> Output stays 0x21, OutValid=1, Ack=0; OutReady=1 -> single Ack[1] pulse, Output=0x21 delivered.
- MAX_BURST=1, Req=4'b1010 -> grants alternate 1,3,1,3; Req drops to 4'b0010 after an Ack[3] -> next grant 1.
- With MUX4A1_ARB_FIXED_PRIO_EN, Req=4'b1111 -> every grant goes to index 0; Req=4'b1100 -> every grant goes to index 2.
